// File: rtl/wb_cmd_master_if.sv
// wb_cmd_master_if -- bundle of the command, response and Wishbone classic
// initiator signals of wb_cmd_master.
//   cmd_*  : request handshake (valid/ready) with write flag, address, byte
//            lanes and write data
//   rsp_*  : response handshake (valid/ready) with read data and timeout flag
//   wb_*   : Wishbone classic initiator port (_o driven by the master)
// modport master : the wb_cmd_master side
// modport slave  : the command source / response sink / Wishbone responder side
interface wb_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;

  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
    output cmd_ready,
    output rsp_valid, rsp_dat, rsp_err,
    input  rsp_ready,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_dat,
    input  cmd_ready,
    input  rsp_valid, rsp_dat, rsp_err,
    output rsp_ready,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_cmd_master.sv
// wb_cmd_master -- turns one command at a time into a Wishbone classic cycle
// and returns a single response (read data or timeout error).
// Ports:
//   clk     : clock, all flops on the rising edge
//   reset   : synchronous, active-high
//   bus     : wb_cmd_master_if.master (cmd / rsp handshakes, Wishbone port)
//   err_cnt : 8-bit saturating timeout count, present only when
//             WB_CMD_MASTER_ERRCNT_EN is defined
// Parameter TIMEOUT_CYCLES (2..255): BUS cycles without ack before abort.
// States: IDLE (accepting) -> BUS (cyc/stb high) -> RESP (response held).
module wb_cmd_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            reset,
  wb_cmd_master_if.master bus
`ifdef WB_CMD_MASTER_ERRCNT_EN
  ,
  output logic [7:0]      err_cnt
`endif
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [7:0]  tmo_cnt;
  logic        cyc_q;
  logic        we_q;
  logic [31:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_dat_q;
  logic        rsp_err_q;

  assign bus.cmd_ready = (state == S_IDLE);
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;   // classic single transfer: stb tracks cyc
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_sel_o  = sel_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tmo_cnt     <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      sel_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            we_q    <= bus.cmd_we;
            adr_q   <= bus.cmd_adr;
            sel_q   <= bus.cmd_sel;
            dat_q   <= bus.cmd_we ? bus.cmd_dat : 32'h0;  // reads drive zero
            cyc_q   <= 1'b1;
            tmo_cnt <= '0;
            state   <= S_BUS;
          end
        end
        S_BUS: begin
          // ack wins over a timeout landing in the same cycle
          if (bus.wb_ack_i) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= we_q ? 32'h0 : bus.wb_dat_i;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else if (tmo_cnt == TMO_LAST) begin
            cyc_q       <= 1'b0;
            rsp_dat_q   <= 32'h0;
            rsp_err_q   <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= S_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef WB_CMD_MASTER_ERRCNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      err_cnt <= '0;
    else if (state == S_BUS && !bus.wb_ack_i && tmo_cnt == TMO_LAST && err_cnt != 8'hFF)
      err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master -- self-checking bench for wb_cmd_master: directed vector
// table, hand-written reset / backpressure sequences and random transactions
// checked against a transaction-level model of the expected response.
module tb_wb_cmd_master;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  wb_cmd_master_if bus ();
`ifdef WB_CMD_MASTER_ERRCNT_EN
  logic [7:0] err_cnt;
  wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus.master), .err_cnt(err_cnt));
`else
  wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .reset(reset), .bus(bus.master));
`endif

  // Responder: acks in stb cycle number ack_delay (1-based), never when 0.
  int          ack_delay = 0;
  int          stb_cnt   = 0;
  logic        force_ack = 1'b0;
  logic [31:0] rd_src    = '0;
  always @(posedge clk) stb_cnt <= bus.wb_stb_o ? stb_cnt + 1 : 0;
  assign bus.wb_ack_i = force_ack | (bus.wb_stb_o && ack_delay != 0 && stb_cnt == ack_delay - 1);
  assign bus.wb_dat_i = rd_src;

  int n_tests = 0;
  int n_fail  = 0;
  int m_err   = 0;   // model of the timeout count

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_errcnt();
`ifdef WB_CMD_MASTER_ERRCNT_EN
    chk("err_cnt", err_cnt, 8'(m_err));
`endif
  endtask

  // Transaction-level expectation: acked within the window or timed out.
  function automatic bit m_is_err(input int ad);
    return (ad == 0) || (ad > T);
  endfunction

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          ad;
    logic [31:0] rd;
    int          rdy;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_stb;
  } vec_t;

  // Entered and left at a negedge with the DUT idle.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat, input int ad, input logic [31:0] rd,
                         input int rdy_wait, input bit keep, input logic exp_err,
                         input logic [31:0] exp_dat, input int exp_stb);
    int nstb, lat, k;
    logic [32:0] held;
    ack_delay     = ad;
    rd_src        = rd;
    bus.cmd_we    = we;
    bus.cmd_adr   = adr;
    bus.cmd_sel   = sel;
    bus.cmd_dat   = dat;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 50) begin @(negedge clk); k++; end
    chk("accept", bus.cmd_ready, 1'b1);
    @(negedge clk);
    if (!keep) bus.cmd_valid = 1'b0;
    nstb = 0; lat = 0;
    for (int c = 1; c <= 300; c++) begin
      if (bus.rsp_valid) begin lat = c; break; end
      if (bus.wb_stb_o) begin
        nstb++;
        chk("wb_fields", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o},
            {2'b11, we, adr, sel, (we ? dat : 32'h0)});
      end else begin
        chk("cyc_eq_stb", bus.wb_cyc_o, 1'b0);
      end
      @(negedge clk);
    end
    chk("stb_cycles", nstb, exp_stb);
    chk("rsp_latency", lat, exp_stb + 1);
    chk("rsp_err", bus.rsp_err, exp_err);
    chk("rsp_dat", bus.rsp_dat, exp_dat);
    if (exp_err && m_err < 255) m_err++;
    held = {bus.rsp_err, bus.rsp_dat};
    repeat (rdy_wait) begin
      chk("rsp_hold", {bus.rsp_valid, bus.rsp_err, bus.rsp_dat, bus.cmd_ready, bus.wb_stb_o},
          {1'b1, held, 1'b0, 1'b0});
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk("rsp_done", {bus.rsp_valid, bus.cmd_ready}, 2'b01);
    chk_errcnt();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 32'h00, 4'hF, 32'h000000A5, 2,  32'h0,        0, 1'b0, 32'h0,        2};
    vecs[1] = '{1'b0, 32'h04, 4'hF, 32'h0,        2,  32'h0000003C, 1, 1'b0, 32'h0000003C, 2};
    vecs[2] = '{1'b0, 32'h08, 4'hF, 32'h0,        0,  32'h11111111, 0, 1'b1, 32'h0,        T};
    vecs[3] = '{1'b0, 32'h0C, 4'hF, 32'h0,        T,  32'hDEADBEEF, 2, 1'b0, 32'hDEADBEEF, T};
    vecs[4] = '{1'b0, 32'h10, 4'h1, 32'h0,        T+1,32'h00001234, 0, 1'b1, 32'h0,        T};
    vecs[5] = '{1'b0, 32'h14, 4'h3, 32'hCAFE0000, 1,  32'h55AA55AA, 3, 1'b0, 32'h55AA55AA, 1};
    vecs[6] = '{1'b1, 32'hFFFFFFFC, 4'hC, 32'hFFFFFFFF, T-1, 32'h77, 0, 1'b0, 32'h0,        T-1};
    vecs[7] = '{1'b1, 32'h20, 4'hF, 32'h12345678, 0,  32'h99,       1, 1'b1, 32'h0,        T};

    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_we = 1'b0; bus.cmd_adr = '0; bus.cmd_sel = '0;
    bus.cmd_dat = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_wb", {bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o, bus.wb_dat_o}, '0);
    chk("reset_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_dat}, '0);
    chk("reset_ready", bus.cmd_ready, 1'b1);
    chk_errcnt();
    reset = 1'b0;
    @(negedge clk);

    // ack outside BUS must be ignored
    force_ack = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ack_idle", {bus.rsp_valid, bus.wb_cyc_o, bus.cmd_ready}, 3'b001);
    end
    force_ack = 1'b0;

    foreach (vecs[i])
      run_txn(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].ad, vecs[i].rd,
              vecs[i].rdy, 1'b0, vecs[i].exp_err, vecs[i].exp_dat, vecs[i].exp_stb);

    // backpressure with cmd_valid held: next command taken right after rsp_ready
    run_txn(1'b0, 32'h40, 4'hF, 32'h0, 2, 32'hA0A0A0A0, 5, 1'b1, 1'b0, 32'hA0A0A0A0, 2);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("back2back_accept", {bus.wb_stb_o, bus.cmd_ready}, 2'b10);
    begin
      int k = 0;
      while (!bus.rsp_valid && k < 50) begin @(negedge clk); k++; end
      chk("back2back_rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_dat}, {2'b10, 32'hA0A0A0A0});
      bus.rsp_ready = 1'b1; @(negedge clk); bus.rsp_ready = 1'b0;
    end

    // reset during the second BUS cycle discards the transaction
    ack_delay = 0;
    bus.cmd_we = 1'b0; bus.cmd_adr = 32'h80; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("rst_bus1", bus.wb_stb_o, 1'b1);
    @(negedge clk);
    chk("rst_bus2", bus.wb_stb_o, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_drop", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid}, 3'b000);
    reset = 1'b0;
    m_err = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_after", {bus.rsp_valid, bus.cmd_ready, bus.wb_stb_o}, 3'b010);
    end
    chk_errcnt();

    // random transactions against the model
    for (int i = 0; i < 40; i++) begin
      logic we; logic [31:0] adr, dat, rd; logic [3:0] sel; int ad; bit e;
      we = 1'($urandom % 2); adr = $urandom; dat = $urandom; rd = $urandom;
      sel = 4'($urandom); ad = $urandom_range(0, T + 4);
      e = m_is_err(ad);
      run_txn(we, adr, sel, dat, ad, rd, $urandom_range(0, 3), 1'b0, e,
              (e || we) ? 32'h0 : rd, e ? T : ad);
    end

`ifdef WB_CMD_MASTER_ERRCNT_EN
    // drive the timeout count into saturation
    for (int i = 0; i < 260; i++)
      run_txn(1'b0, 32'h0, 4'hF, 32'h0, 0, 32'h0, 0, 1'b0, 1'b1, 32'h0, T);
    chk("err_cnt_sat", err_cnt, 8'hFF);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
